// File: rtl/cmip_app_cnt_mc.sv
// Multi-channel event counter bank with wrap/saturate policy, sticky overflow,
// delayed global clear, atomic snapshot into shadows and indexed shadow readback.
module cmip_app_cnt_mc #(
   parameter int CH_NUM  = 8,
   parameter int WDTH    = 16,
   parameter int IDX_W   = 3,
   parameter int SAT_EN  = 0,
   parameter int CLR_DLY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic [CH_NUM-1:0] i_vld,
   input  logic              i_snap,
   input  logic              i_snap_clr,
   input  logic              i_rd_req,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic              o_rd_vld,
   output logic [WDTH-1:0]   o_rd_data,
   output logic [CH_NUM-1:0] o_ovf,
   output logic              o_snap_done
);

   localparam logic [WDTH-1:0] CNT_MAX = '1;

   logic [CLR_DLY-1:0] clr_pipe_q, clr_pipe_d;
   logic               clr_eff;
   logic [WDTH-1:0]    cnt_q    [CH_NUM];
   logic [WDTH-1:0]    cnt_d    [CH_NUM];
   logic [WDTH-1:0]    shadow_q [CH_NUM];
   logic [WDTH-1:0]    shadow_d [CH_NUM];
   logic [CH_NUM-1:0]  ovf_q, ovf_d;
   logic               rd_vld_q;
   logic [WDTH-1:0]    rd_data_q, rd_data_d;
   logic               snap_done_q;

   assign clr_eff = clr_pipe_q[CLR_DLY-1];

   always_comb begin
      clr_pipe_d    = clr_pipe_q;
      clr_pipe_d[0] = i_clr;
      for (int i = 1; i < CLR_DLY; i++) begin
         clr_pipe_d[i] = clr_pipe_q[i-1];
      end
   end

   // Per-channel priority: delayed clear, then snapshot restart, then increment.
   always_comb begin
      ovf_d = ovf_q;
      for (int k = 0; k < CH_NUM; k++) begin
         cnt_d[k]    = cnt_q[k];
         shadow_d[k] = i_snap ? cnt_q[k] : shadow_q[k];
         if (clr_eff) begin
            cnt_d[k] = '0;
            ovf_d[k] = 1'b0;
         end else if (i_snap && i_snap_clr) begin
            // The snap-cycle event opens the new interval so nothing is lost.
            cnt_d[k] = {{(WDTH-1){1'b0}}, i_vld[k]};
         end else if (i_vld[k]) begin
            if (cnt_q[k] == CNT_MAX) begin
               ovf_d[k] = 1'b1;
               cnt_d[k] = (SAT_EN != 0) ? CNT_MAX : '0;
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Reads see the shadow as held before the edge; unmapped indices return zero.
   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_req) begin
         rd_data_d = '0;
         for (int k = 0; k < CH_NUM; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
               rd_data_d = shadow_q[k];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         clr_pipe_q  <= '0;
         ovf_q       <= '0;
         rd_vld_q    <= 1'b0;
         rd_data_q   <= '0;
         snap_done_q <= 1'b0;
         for (int k = 0; k < CH_NUM; k++) begin
            cnt_q[k]    <= '0;
            shadow_q[k] <= '0;
         end
      end else begin
         clr_pipe_q  <= clr_pipe_d;
         ovf_q       <= ovf_d;
         rd_vld_q    <= i_rd_req;
         rd_data_q   <= rd_data_d;
         snap_done_q <= i_snap;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
      end
   end

   assign o_rd_vld    = rd_vld_q;
   assign o_rd_data   = rd_data_q;
   assign o_ovf       = ovf_q;
   assign o_snap_done = snap_done_q;

endmodule

// File: tb/tb_cmip_app_cnt_mc.sv
// Bench for cmip_app_cnt_mc: a wrap and a saturate instance share stimulus and
// are compared with directed constants and a behavioural reference model.
module tb_cmip_app_cnt_mc;

   localparam int CH   = 6;
   localparam int W    = 4;
   localparam int IW   = 3;
   localparam int DLY  = 2;
   localparam int MAXV = 15;

   logic          clk = 1'b0;
   logic          rst, clr, snap, snap_clr, rd_req;
   logic [CH-1:0] vld;
   logic [IW-1:0] rd_idx;
   logic          rd_vld_w, rd_vld_s, sd_w, sd_s;
   logic [W-1:0]  rd_data_w, rd_data_s;
   logic [CH-1:0] ovf_w, ovf_s;

   int checks = 0;
   int errors = 0;

   // reference model state, index 0 = wrap instance, 1 = saturate instance
   int            m_cnt [2][CH];
   int            m_sh  [2][CH];
   logic [CH-1:0] m_ovf [2];
   int            m_rd  [2];
   logic          m_rd_vld, m_sd;
   bit            m_clr [$];

   always #5 clk = ~clk;

   cmip_app_cnt_mc #(.CH_NUM(CH), .WDTH(W), .IDX_W(IW), .SAT_EN(0), .CLR_DLY(DLY)) u_wrap (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_vld(vld), .i_snap(snap),
      .i_snap_clr(snap_clr), .i_rd_req(rd_req), .i_rd_idx(rd_idx),
      .o_rd_vld(rd_vld_w), .o_rd_data(rd_data_w), .o_ovf(ovf_w), .o_snap_done(sd_w));

   cmip_app_cnt_mc #(.CH_NUM(CH), .WDTH(W), .IDX_W(IW), .SAT_EN(1), .CLR_DLY(DLY)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_vld(vld), .i_snap(snap),
      .i_snap_clr(snap_clr), .i_rd_req(rd_req), .i_rd_idx(rd_idx),
      .o_rd_vld(rd_vld_s), .o_rd_data(rd_data_s), .o_ovf(ovf_s), .o_snap_done(sd_s));

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < CH; k++) begin
            m_cnt[s][k] = 0;
            m_sh[s][k]  = 0;
         end
         m_ovf[s] = '0;
         m_rd[s]  = 0;
      end
      m_rd_vld = 1'b0;
      m_sd     = 1'b0;
      m_clr.delete();
      repeat (DLY) m_clr.push_back(1'b0);
   endtask

   // One clock edge of the specified behaviour, evaluated on the inputs held before it.
   task automatic model_step();
      bit ce;
      if (rst) begin
         model_reset();
         return;
      end
      ce = m_clr.pop_front();
      m_clr.push_back(clr);
      for (int s = 0; s < 2; s++) begin
         if (rd_req) m_rd[s] = (int'(rd_idx) < CH) ? m_sh[s][rd_idx] : 0;
         for (int k = 0; k < CH; k++) begin
            if (snap) m_sh[s][k] = m_cnt[s][k];
            if (ce) begin
               m_cnt[s][k] = 0;
               m_ovf[s][k] = 1'b0;
            end else if (snap && snap_clr) begin
               m_cnt[s][k] = vld[k] ? 1 : 0;
            end else if (vld[k]) begin
               if (m_cnt[s][k] + 1 > MAXV) begin
                  m_ovf[s][k] = 1'b1;
                  m_cnt[s][k] = (s == 1) ? MAXV : 0;
               end else begin
                  m_cnt[s][k] = m_cnt[s][k] + 1;
               end
            end
         end
      end
      m_rd_vld = rd_req;
      m_sd     = snap;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      clr = 0; vld = '0; snap = 0; snap_clr = 0; rd_req = 0; rd_idx = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      vld = '1;
      rst = 1'b1;
      model_reset();
      #1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (((s ? ovf_s : ovf_w) !== '0) || ((s ? rd_vld_s : rd_vld_w) !== 1'b0) ||
             ((s ? rd_data_s : rd_data_w) !== '0) || ((s ? sd_s : sd_w) !== 1'b0)) begin
            errors++;
            $display("FAIL reset_async s%0d: ovf=%b rd_vld=%b rd_data=%0d snap_done=%b, required all 0",
                     s, s ? ovf_s : ovf_w, s ? rd_vld_s : rd_vld_w, s ? rd_data_s : rd_data_w, s ? sd_s : sd_w);
         end
      end
      tick(); tick();
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ((s ? ovf_s : ovf_w) !== '0) begin
            errors++;
            $display("FAIL reset_held_ovf s%0d: got %b required 0", s, s ? ovf_s : ovf_w);
         end
      end
      rst = 1'b0;
      vld = 6'b000001;
      repeat (10) tick();
      vld = '0; snap = 1;
      tick();
      snap = 0;
      checks++;
      if (sd_w !== 1'b1 || sd_s !== 1'b1) begin
         errors++;
         $display("FAIL snap_done: got %b/%b required 1", sd_w, sd_s);
      end
      rd_req = 1; rd_idx = 0;
      tick();
      rd_req = 0;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ((s ? rd_vld_s : rd_vld_w) !== 1'b1 || (s ? rd_data_s : rd_data_w) !== 4'd10) begin
            errors++;
            $display("FAIL count10 s%0d: vld=%b data=%0d required vld=1 data=10",
                     s, s ? rd_vld_s : rd_vld_w, s ? rd_data_s : rd_data_w);
         end
      end
      tick();
      checks++;
      if (rd_vld_w !== 1'b0 || rd_data_w !== 4'd10) begin
         errors++;
         $display("FAIL rd_vld_one_cycle: vld=%b data=%0d required vld=0 data=10", rd_vld_w, rd_data_w);
      end
   endtask

   task automatic test_wrap_sat();
      do_reset();
      vld = 6'b000010;
      repeat (17) tick();
      vld = '0; snap = 1;
      tick();
      snap = 0; rd_req = 1; rd_idx = 1;
      tick();
      rd_req = 0;
      checks++;
      if (rd_data_w !== 4'd1) begin
         errors++;
         $display("FAIL wrap_value: got %0d required 1", rd_data_w);
      end
      checks++;
      if (rd_data_s !== 4'd15) begin
         errors++;
         $display("FAIL sat_value: got %0d required 15", rd_data_s);
      end
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ((s ? ovf_s : ovf_w) !== 6'b000010) begin
            errors++;
            $display("FAIL ovf_ch1 s%0d: got %b required 000010", s, s ? ovf_s : ovf_w);
         end
      end
   endtask

   task automatic test_snap_clr();
      int pulses, sum;
      do_reset();
      vld = 6'b000100; snap = 1; snap_clr = 1;
      tick();
      pulses = 1; sum = 0;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 8; c++) begin
            snap = (c == 7); snap_clr = (c == 7);
            rd_req = (c == 0 && i > 0); rd_idx = 2;
            tick();
            pulses++;
            if (c == 0 && i > 0) begin
               sum += int'(rd_data_w);
               checks++;
               if (rd_data_w !== 4'd8 || rd_data_s !== 4'd8) begin
                  errors++;
                  $display("FAIL interval_%0d: got %0d/%0d required 8", i, rd_data_w, rd_data_s);
               end
            end
         end
      end
      vld = '0; snap = 0; snap_clr = 0; rd_req = 1;
      tick();
      sum += int'(rd_data_w);
      checks++;
      if (rd_data_w !== 4'd8) begin
         errors++;
         $display("FAIL interval_last: got %0d required 8", rd_data_w);
      end
      rd_req = 0; snap = 1;
      tick();
      snap = 0; rd_req = 1;
      tick();
      rd_req = 0;
      sum += int'(rd_data_w);
      checks++;
      if (sum !== pulses) begin
         errors++;
         $display("FAIL snap_clr_sum: got %0d required %0d", sum, pulses);
      end
   endtask

   task automatic test_clr_timing();
      do_reset();
      for (int c = 0; c < 16; c++) begin
         vld = {2'b00, (c < 5), 2'b00, 1'b1};
         tick();
      end
      vld = 6'b001000; clr = 1; snap = 1; rd_req = 1; rd_idx = 3;
      tick();
      clr = 0;
      checks++;
      if (ovf_w !== 6'b000001 || ovf_s !== 6'b000001) begin
         errors++;
         $display("FAIL clr_ovf_N: got %b/%b required 000001", ovf_w, ovf_s);
      end
      for (int j = 1; j <= 5; j++) begin
         tick();
         case (j)
            1: begin
               checks++;
               if (ovf_w !== 6'b000001) begin
                  errors++;
                  $display("FAIL clr_ovf_N1: got %b required 000001", ovf_w);
               end
            end
            2: begin
               checks++;
               if (ovf_w !== '0 || ovf_s !== '0 || rd_data_w !== 4'd6) begin
                  errors++;
                  $display("FAIL clr_N2: ovf=%b/%b cnt=%0d required ovf=0 cnt=6", ovf_w, ovf_s, rd_data_w);
               end
            end
            3: begin
               checks++;
               if (rd_data_w !== 4'd7) begin
                  errors++;
                  $display("FAIL clr_cnt_N1: got %0d required 7", rd_data_w);
               end
            end
            4: begin
               checks++;
               if (rd_data_w !== 4'd0 || rd_data_s !== 4'd0) begin
                  errors++;
                  $display("FAIL clr_cnt_N2: got %0d/%0d required 0", rd_data_w, rd_data_s);
               end
            end
            default: begin
               checks++;
               if (rd_data_w !== 4'd1) begin
                  errors++;
                  $display("FAIL clr_cnt_N3: got %0d required 1", rd_data_w);
               end
            end
         endcase
      end
      idle_inputs();
   endtask

   task automatic test_collision();
      do_reset();
      vld = 6'b010000;
      repeat (9) tick();
      vld = '0; clr = 1;
      tick();
      clr = 0;
      tick();
      snap = 1; vld = 6'b010000;
      tick();
      snap = 0; vld = '0;
      checks++;
      if (sd_w !== 1'b1) begin
         errors++;
         $display("FAIL coll_snap_done: got %b required 1", sd_w);
      end
      rd_req = 1; rd_idx = 4;
      tick();
      rd_req = 0;
      checks++;
      if (rd_data_w !== 4'd9 || rd_data_s !== 4'd9) begin
         errors++;
         $display("FAIL coll_shadow: got %0d/%0d required 9", rd_data_w, rd_data_s);
      end
      snap = 1;
      tick();
      snap = 0; rd_req = 1;
      tick();
      rd_req = 0;
      checks++;
      if (rd_data_w !== 4'd0) begin
         errors++;
         $display("FAIL coll_counter: got %0d required 0", rd_data_w);
      end
   endtask

   task automatic test_readback();
      logic [W-1:0] exp;
      do_reset();
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < CH; k++) vld[k] = (k >= c);
         tick();
      end
      vld = '0; snap = 1;
      tick();
      snap = 0; rd_req = 1; rd_idx = 3'(CH);
      tick();
      rd_req = 0;
      checks++;
      if (rd_vld_w !== 1'b1 || rd_data_w !== '0) begin
         errors++;
         $display("FAIL idx_out_of_range: vld=%b data=%0d required vld=1 data=0", rd_vld_w, rd_data_w);
      end
      vld = 6'b000001;
      tick();
      vld = '0; snap = 1; rd_req = 1; rd_idx = 0;
      tick();
      snap = 0;
      checks++;
      if (rd_data_w !== 4'd1) begin
         errors++;
         $display("FAIL read_during_snap: got %0d required 1", rd_data_w);
      end
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i);
         tick();
         exp = (i >= CH) ? 4'd0 : (i == 0) ? 4'd2 : 4'(i + 1);
         checks++;
         if (rd_vld_s !== 1'b1 || rd_data_s !== exp) begin
            errors++;
            $display("FAIL b2b_idx%0d: vld=%b data=%0d required vld=1 data=%0d", i, rd_vld_s, rd_data_s, exp);
         end
      end
      rd_idx = 3;
      tick();
      rd_req = 0;
      tick();
      checks++;
      if (rd_vld_w !== 1'b0 || rd_data_w !== 4'd4) begin
         errors++;
         $display("FAIL rd_hold: vld=%b data=%0d required vld=0 data=4", rd_vld_w, rd_data_w);
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      clr = 1;
      tick();
      clr = 0; rst = 1;
      model_reset();
      tick();
      rst = 0; vld = 6'b000010;
      repeat (4) tick();
      vld = '0; snap = 1;
      tick();
      snap = 0; rd_req = 1; rd_idx = 1;
      tick();
      rd_req = 0;
      checks++;
      if (rd_data_w !== 4'd4) begin
         errors++;
         $display("FAIL inflight_clr_killed: got %0d required 4", rd_data_w);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_d;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         vld      = CH'($urandom);
         clr      = ($urandom_range(0, 19) == 0);
         snap     = ($urandom_range(0, 3) == 0);
         snap_clr = $urandom_range(0, 1);
         rd_req   = $urandom_range(0, 1);
         rd_idx   = 3'($urandom_range(0, 7));
         tick();
         for (int s = 0; s < 2; s++) begin
            exp_d = W'(m_rd[s]);
            checks++;
            if ((s ? ovf_s : ovf_w) !== m_ovf[s]) begin
               errors++;
               $display("FAIL rnd_ovf s%0d cyc%0d: got %b required %b", s, n, s ? ovf_s : ovf_w, m_ovf[s]);
            end
            checks++;
            if ((s ? rd_vld_s : rd_vld_w) !== m_rd_vld || (s ? rd_data_s : rd_data_w) !== exp_d) begin
               errors++;
               $display("FAIL rnd_read s%0d cyc%0d: vld=%b data=%0d required vld=%b data=%0d",
                        s, n, s ? rd_vld_s : rd_vld_w, s ? rd_data_s : rd_data_w, m_rd_vld, exp_d);
            end
            checks++;
            if ((s ? sd_s : sd_w) !== m_sd) begin
               errors++;
               $display("FAIL rnd_snap_done s%0d cyc%0d: got %b required %b", s, n, s ? sd_s : sd_w, m_sd);
            end
         end
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_wrap_sat();
      test_snap_clr();
      test_clr_timing();
      test_collision();
      test_readback();
      test_reset_inflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
